// File: rtl/pid_core.sv
// PID compute stage: accepts a setpoint/measurement pair, updates the error,
// integral and derivative terms, and emits one saturated signed 8-bit control word.
module pid_core #(
  parameter int FRAC_SHIFT = 2,
  parameter int INT_SHIFT  = 4,
  parameter int ACC_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [7:0] setpoint,
  input  logic [7:0] measurement,
  input  logic [3:0] kp,
  input  logic [3:0] ki,
  input  logic [3:0] kd,
  input  logic       clear_integ,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] ctrl_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR  = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]              r_state;
  logic [7:0]              r_sp;
  logic [7:0]              r_meas;
  logic [3:0]              r_kp;
  logic [3:0]              r_ki;
  logic [3:0]              r_kd;
  logic signed [8:0]       r_e;
  logic signed [9:0]       r_d;
  logic signed [8:0]       r_eprev;
  logic signed [ACC_W-1:0] r_integ;
  logic [7:0]              r_ctrl;

  logic signed [8:0]       w_e;
  logic signed [9:0]       w_d;
  logic signed [ACC_W:0]   w_isum;
  logic signed [ACC_W-1:0] w_integ_sat;
  logic signed [31:0]      w_p;
  logic signed [31:0]      w_i;
  logic signed [31:0]      w_dd;
  logic signed [31:0]      w_sum;
  logic signed [31:0]      w_r;
  logic [7:0]              w_ctrl;

  assign w_e    = {1'b0, r_sp} - {1'b0, r_meas};
  assign w_d    = {w_e[8], w_e} - {r_eprev[8], r_eprev};
  assign w_isum = {r_integ[ACC_W-1], r_integ} + {{(ACC_W-8){w_e[8]}}, w_e};

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    w_integ_sat = w_isum[ACC_W-1:0];
    if (w_isum[ACC_W] != w_isum[ACC_W-1])
      w_integ_sat = w_isum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  assign w_p   = $signed({28'd0, r_kp}) * $signed({{23{r_e[8]}}, r_e});
  assign w_i   = ($signed({28'd0, r_ki}) * $signed({{(32-ACC_W){r_integ[ACC_W-1]}}, r_integ})) >>> INT_SHIFT;
  assign w_dd  = $signed({28'd0, r_kd}) * $signed({{22{r_d[9]}}, r_d});
  assign w_sum = w_p + w_i + w_dd;
  assign w_r   = w_sum >>> FRAC_SHIFT;

  always_comb begin
    w_ctrl = w_r[7:0];
    if (w_r > 32'sd127)
      w_ctrl = 8'h7F;
    else if (w_r < -32'sd128)
      w_ctrl = 8'h80;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sp    <= '0;
      r_meas  <= '0;
      r_kp    <= '0;
      r_ki    <= '0;
      r_kd    <= '0;
      r_e     <= '0;
      r_d     <= '0;
      r_eprev <= '0;
      r_integ <= '0;
      r_ctrl  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_integ) begin
            r_integ <= '0;
            r_eprev <= '0;
          end
          if (sample_valid) begin
            r_sp    <= setpoint;
            r_meas  <= measurement;
            r_kp    <= kp;
            r_ki    <= ki;
            r_kd    <= kd;
            r_state <= S_ERR;
          end
        end
        S_ERR: begin
          r_e     <= w_e;
          r_d     <= w_d;
          r_integ <= w_integ_sat;
          r_eprev <= w_e;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_ctrl  <= w_ctrl;
          r_state <= S_OUT;
        end
        default: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sample_ready = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_OUT);
  assign ctrl_out     = r_ctrl;

endmodule

// File: tb/tb_pid_core.sv
// Directed-vector bench for pid_core with hand-computed expected control words.
module tb_pid_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic       sample_ready;
  logic [7:0] setpoint;
  logic [7:0] measurement;
  logic [3:0] kp;
  logic [3:0] ki;
  logic [3:0] kd;
  logic       clear_integ;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ctrl_out;

  int n_checks = 0;
  int n_fail   = 0;

  pid_core #(.FRAC_SHIFT(2), .INT_SHIFT(4), .ACC_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .setpoint     (setpoint),
    .measurement  (measurement),
    .kp           (kp),
    .ki           (ki),
    .kd           (kd),
    .clear_integ  (clear_integ),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ctrl_out     (ctrl_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one sample, checks the 2-edge latency and the result; leaves OUT if out_ready.
  task automatic run_sample(input string tag, input logic [7:0] sp, input logic [7:0] meas,
                            input logic [3:0] p, input logic [3:0] i, input logic [3:0] d,
                            input logic clr, input logic [7:0] exp);
    int waitc;
    int lat;
    waitc = 0;
    lat   = 0;
    while (!sample_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    check({tag, " ready"}, {31'd0, sample_ready}, 32'd1);
    setpoint     = sp;
    measurement  = meas;
    kp           = p;
    ki           = i;
    kd           = d;
    clear_integ  = clr;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    clear_integ  = 1'b0;
    setpoint     = 8'hAA;
    measurement  = 8'h55;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " lat"}, lat, 32'd2);
    check({tag, " ctrl"}, {24'd0, ctrl_out}, {24'd0, exp});
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; setpoint = '0; measurement = '0;
    kp = '0; ki = '0; kd = '0; clear_integ = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", {31'd0, sample_ready}, 32'd1);
    check("rst valid", {31'd0, out_valid}, 32'd0);
    check("rst ctrl",  {24'd0, ctrl_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_sample("prop",     8'd100, 8'd60,  4'd2,  4'd0, 4'd0, 1'b0, 8'h14);
    run_sample("sat_hi",   8'd255, 8'd0,   4'd15, 4'd0, 4'd0, 1'b0, 8'h7F);
    run_sample("sat_lo",   8'd0,   8'd255, 4'd15, 4'd0, 4'd0, 1'b0, 8'h80);
    run_sample("floor",    8'd0,   8'd1,   4'd1,  4'd0, 4'd0, 1'b1, 8'hFF);
    run_sample("zero_g",   8'd200, 8'd3,   4'd0,  4'd0, 4'd0, 1'b0, 8'h00);

    run_sample("int1",     8'd16,  8'd0,   4'd0,  4'd4, 4'd0, 1'b1, 8'h01);
    run_sample("int2",     8'd16,  8'd0,   4'd0,  4'd4, 4'd0, 1'b0, 8'h02);
    run_sample("int_clr",  8'd16,  8'd0,   4'd0,  4'd4, 4'd0, 1'b1, 8'h01);

    run_sample("der1",     8'd40,  8'd0,   4'd0,  4'd0, 4'd1, 1'b1, 8'h0A);
    run_sample("der2",     8'd40,  8'd0,   4'd0,  4'd0, 4'd1, 1'b0, 8'h00);
    run_sample("der_neg",  8'd0,   8'd0,   4'd0,  4'd0, 4'd4, 1'b0, 8'hD8);

    // 130 x 255 exceeds 32767: a wrapping accumulator would turn negative.
    for (int n = 0; n < 130; n++)
      run_sample("rail_fill", 8'd255, 8'd0, 4'd0, 4'd0, 4'd0, (n == 0), 8'h00);
    run_sample("rail_hold", 8'd0,   8'd255, 4'd0, 4'd15, 4'd0, 1'b0, 8'h7F);

    out_ready = 1'b0;
    run_sample("bp", 8'd100, 8'd60, 4'd2, 4'd0, 4'd0, 1'b1, 8'h14);
    for (int k = 0; k < 5; k++) begin
      sample_valid = 1'b1;
      setpoint     = 8'd0;
      @(posedge clk); #1;
      check("bp valid", {31'd0, out_valid}, 32'd1);
      check("bp ctrl",  {24'd0, ctrl_out}, 32'h14);
      check("bp ready", {31'd0, sample_ready}, 32'd0);
    end
    sample_valid = 1'b0;
    out_ready    = 1'b1;
    @(posedge clk); #1;
    check("bp rel valid", {31'd0, out_valid}, 32'd0);
    check("bp rel ready", {31'd0, sample_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp idle", {31'd0, out_valid}, 32'd0);

    setpoint = 8'd100; measurement = 8'd0; kp = 4'd0; ki = 4'd4; kd = 4'd1;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst valid", {31'd0, out_valid}, 32'd0);
    check("arst ctrl",  {24'd0, ctrl_out}, 32'd0);
    check("arst ready", {31'd0, sample_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst no_out", {31'd0, out_valid}, 32'd0);
    run_sample("post_rst", 8'd16, 8'd0, 4'd0, 4'd4, 4'd1, 1'b0, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_core.md
Name: pid_core

Overview:
- Sequential PID compute stage that sits directly upstream of the top-level output adder/driver on the PID controller tile.
- Accepts a setpoint/measurement sample pair over a valid/ready handshake and computes error, integral and derivative terms.
- Produces one saturated signed 8-bit control word per sample over a valid/ready handshake.
- The downstream stage sums or drives this word onto the output pins.

Parameters:
- FRAC_SHIFT, 2, arithmetic right shift applied to the final PID sum (fixed-point scaling of gains).
- INT_SHIFT, 4, arithmetic right shift applied to ki*integ before summing.
- ACC_W, 16, width of the signed saturating integral accumulator.

Ports:
- clk  input  1  single clock; all state is updated on its rising edge.
- rst  input  1  asynchronous, active-high reset. The top level derives it as the inverse of its rst_n pin.
- sample_valid  input  1  setpoint/measurement pair present.
- sample_ready  output  1  block can accept a sample.
- setpoint  input  8  unsigned target value.
- measurement  input  8  unsigned plant feedback.
- kp  input  4  unsigned proportional gain; sampled at accept.
- ki  input  4  unsigned integral gain; sampled at accept.
- kd  input  4  unsigned derivative gain; sampled at accept.
- clear_integ  input  1  zero the integral accumulator and the previous-error register.
- out_valid  output  1  ctrl_out holds a result.
- out_ready  input  1  downstream accepts the result.
- ctrl_out  output  8  signed two's-complement control word.

Behaviour:
- Reset (async, rst=1): state=IDLE, sample_ready=1, out_valid=0, ctrl_out=0x00, integ=0, e_prev=0. Any in-flight computation is discarded and no output is produced for it.
- States: IDLE -> ERR -> CALC -> OUT -> IDLE. sample_ready=1 only in IDLE; out_valid=1 only in OUT.
- IDLE: the accept edge is sample_valid&sample_ready. On it, capture setpoint, measurement, kp, ki, kd and go to ERR.
- ERR (1 cycle):
  - e = setpoint - measurement, 9-bit signed, range -255..255.
  - d = e - e_prev, 10-bit signed.
  - integ = sat_ACC_W(integ + e), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - e_prev <= e. Go to CALC.
- CALC (1 cycle):
  - sum = kp*e + ((ki*integ) >>> INT_SHIFT) + kd*d. Evaluate signed with at least 24 bits so no intermediate overflow occurs.
  - r = sum >>> FRAC_SHIFT, arithmetic shift (floor toward -inf).
  - ctrl_out <= clamp(r, -128, 127). Go to OUT.
- OUT: ctrl_out and out_valid are held stable until out_ready=1. On that edge go to IDLE; sample_ready=1 the following cycle.
- Latency: out_valid rises 2 edges after the accept edge. Minimum sample period is 4 cycles when out_ready is tied high.
- ctrl_out keeps its last value after leaving OUT; it changes only at the CALC->OUT edge.
- First sample after reset or clear: e_prev=0, so d=e.
- clear_integ takes effect only in IDLE: it sets integ=0 and e_prev=0 on that edge. It is ignored in other states.
  - If it coincides with an accept edge, the clear applies first; the accepted sample then computes integ=e and d=e.
- Integral saturation holds at the rail (no wrap). Subsequent errors of opposite sign move integ off the rail normally.
- Gains are all-zero capable: kp=ki=kd=0 gives ctrl_out=0x00.
- sample_valid while not ready is ignored. Inputs need only be stable on the accept edge.

Test Plan:
- Reset then kp=2, ki=0, kd=0, sp=100, meas=60 -> e=40, sum=80, out_valid 2 edges after accept, ctrl_out=20 (0x14).
- kp=15, sp=255, meas=0 -> sum=3825, r=956 -> ctrl_out=127 (0x7F). Then sp=0, meas=255 -> r=-957 -> ctrl_out=-128 (0x80).
- Integral: kp=0, kd=0, ki=4, sp=16, meas=0, two samples -> integ 16 then 32; ctrl_out=1 then 2. Assert clear_integ in IDLE, repeat -> ctrl_out=1.
- Derivative: kp=0, ki=0, kd=1, sp=40, meas=0, two samples after reset -> d=40 then 0; ctrl_out=10 then 0.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid=1, ctrl_out stable, sample_ready=0, further sample_valid ignored. Raise out_ready -> IDLE next edge.
- Assert rst during CALC -> out_valid=0, ctrl_out=0, sample_ready=1 immediately. A fresh sample then computes with integ=0 and e_prev=0.
